// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and small helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bytes never fault; halfwords need an even offset; words need offset 0.
  // Any funct3 outside the RV32I load set is treated as a fault.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte enables follow the access size shifted into the addressed lane.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] data;
    case (f3[1:0])
      2'b00:   data = {4{wdata[7:0]}};
      2'b01:   data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/lsu_extract.sv
// Picks the addressed lane out of a read word and sign/zero-extends it to 32 bits.
module lsu_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  f3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] ext_o
);

  logic [31:0] lane;

  // Shift the addressed byte/halfword down to bit 0, then extend by funct3.
  always_comb begin
    lane  = rdata_i >> {off_i, 3'b000};
    ext_o = '0;
    case (f3_i)
      F3_B:    ext_o = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   ext_o = {24'b0, lane[7:0]};
      F3_H:    ext_o = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   ext_o = {16'b0, lane[15:0]};
      F3_W:    ext_o = rdata_i;
      default: ext_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one handshaked data-memory access per request, with load
// extraction into md and store lane steering; busy stalls the core meanwhile.
module lsu
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_f3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] md,
  output logic          done,
  output logic          err,
  output logic          busy
);

  lsu_state_e    state_q, state_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic          err_q, err_d;
  logic [DW-1:0] md_q, md_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] ext;
  logic          bad_req;

  lsu_extract u_extract (
    .rdata_i (mem_rdata),
    .f3_i    (f3_q),
    .off_i   (off_q),
    .ext_o   (ext)
  );

  // Stores only define SB/SH/SW, so the unsigned encodings are rejected for them too.
  assign bad_req = misaligned(req_f3, req_addr[1:0]) | (req_we & req_f3[2]);

  // State register plus every latched transaction field; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      err_q       <= 1'b0;
      md_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      err_q       <= err_d;
      md_q        <= md_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state and datapath updates; memory-side values are fixed at accept time so they stay stable in REQ.
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    off_d       = off_q;
    err_d       = err_q;
    md_d        = md_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          f3_d  = req_f3;
          off_d = req_addr[1:0];
          if (bad_req) begin
            err_d   = 1'b1;
            state_d = S_DONE;
            if (!req_we) begin
              md_d = '0;
            end
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[AW-1:2], 2'b00};
            mem_be_d    = byte_en(req_f3, req_addr[1:0]);
            mem_wdata_d = store_data(req_f3, req_wdata);
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          md_d    = ext;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE) | req_valid;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign md        = md_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
